// File: rtl/au_neg_c_serial.sv
// Digit-serial conditional two's complementer: z = neg ? -a : a, DIGIT bits per clock, LSB first.
// Optional registered signed-overflow flag on port ovf when AU_NEG_C_SERIAL_OVF_EN is defined.
module au_neg_c_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             busy
`ifdef AU_NEG_C_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int PW   = NDIG * DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   opr;
  logic [PW-1:0]   res, res_nxt;
  logic            negr, carry;
  logic [CW-1:0]   cnt;
  logic            last, accept;
  logic [DIGIT:0]  d;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(NDIG - 1));

  // Operand shifts right one digit per cycle, so the active slice is always at the bottom.
  assign d = {1'b0, opr[DIGIT-1:0] ^ {DIGIT{negr}}} + (DIGIT+1)'(carry);

  // Result fills from the top; after NDIG shifts it sits fully aligned.
  generate
    if (NDIG == 1) begin : g_one
      assign res_nxt = d[DIGIT-1:0];
    end else begin : g_multi
      assign res_nxt = {d[DIGIT-1:0], res[PW-1:DIGIT]};
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opr   <= '0;
      res   <= '0;
      negr  <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      z     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        opr   <= PW'(a);
        negr  <= neg;
        carry <= neg;
        cnt   <= '0;
      end else if (state == RUN) begin
        opr   <= opr >> DIGIT;
        res   <= res_nxt;
        carry <= d[DIGIT];
        cnt   <= cnt + CW'(1);
        if (last) z <= res_nxt[WIDTH-1:0];
      end
    end
  end

`ifdef AU_NEG_C_SERIAL_OVF_EN
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
  logic ovf_pend;

  // Decided at capture since the operand register is consumed by the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_pend <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (accept) ovf_pend <= neg && (a == MSB);
      if (state == RUN && last) ovf <= ovf_pend;
    end
  end
`endif

endmodule

// File: tb/tb_au_neg_c_serial.sv
// Self-checking bench for au_neg_c_serial: vector table, handshake corner cases, randomized ops vs model.
module tb_au_neg_c_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv16 = 1'b0, neg16 = 1'b0, ordy16 = 1'b1;
  logic [15:0] a16 = '0;
  logic        ir16, ov16, busy16;
  logic [15:0] z16;
  logic        iv10 = 1'b0, neg10 = 1'b0, ordy10 = 1'b1;
  logic [9:0]  a10 = '0;
  logic        ir10, ov10, busy10;
  logic [9:0]  z10;
`ifdef AU_NEG_C_SERIAL_OVF_EN
  logic        ovf16, ovf10;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  au_neg_c_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .neg(neg16),
    .out_valid(ov16), .out_ready(ordy16), .z(z16), .busy(busy16)
`ifdef AU_NEG_C_SERIAL_OVF_EN
    , .ovf(ovf16)
`endif
  );

  au_neg_c_serial #(.WIDTH(10), .DIGIT(4)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv10), .in_ready(ir10), .a(a10), .neg(neg10),
    .out_valid(ov10), .out_ready(ordy10), .z(z10), .busy(busy10)
`ifdef AU_NEG_C_SERIAL_OVF_EN
    , .ovf(ovf10)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic        neg;
    logic [15:0] z;
    logic        ovf;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic on the whole word.
  function automatic logic [15:0] model16(input logic [15:0] av, input logic nv);
    return nv ? 16'(17'h10000 - {1'b0, av}) : av;
  endfunction

  // Called at posedge+1 with the DUT idle; returns idle after the handoff.
  task automatic op16(input logic [15:0] av, input logic nv, input int hold, input bit noise,
                      input logic [15:0] ez, input logic eovf);
    int lat;
    chk("in_ready_idle", ir16, 1);
    a16 = av; neg16 = nv; iv16 = 1'b1; ordy16 = (hold == 0);
    @(posedge clk); #1;
    iv16 = 1'b0; lat = 0;
    while (!ov16 && lat < 40) begin
      if (noise) begin
        iv16 = 1'($urandom_range(0, 1)); a16 = 16'($urandom); neg16 = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, 4);
    chk("z", z16, ez);
`ifdef AU_NEG_C_SERIAL_OVF_EN
    chk("ovf", ovf16, eovf);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", ov16, 1);
      chk("hold_z", z16, ez);
      chk("hold_in_ready", ir16, 0);
      chk("hold_busy", busy16, 1);
    end
    ordy16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    chk("handoff_valid", ov16, 0);
    chk("handoff_busy", busy16, 0);
    chk("handoff_z_kept", z16, ez);
  endtask

  task automatic op10(input logic [9:0] av, input logic nv, input logic [9:0] ez, input logic eovf);
    int lat;
    a10 = av; neg10 = nv; iv10 = 1'b1;
    @(posedge clk); #1;
    iv10 = 1'b0; lat = 0;
    while (!ov10 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("w10_latency", lat, 3);
    chk("w10_z", z10, ez);
`ifdef AU_NEG_C_SERIAL_OVF_EN
    chk("w10_ovf", ovf10, eovf);
`endif
    @(posedge clk); #1;
    chk("w10_handoff_valid", ov10, 0);
  endtask

  initial begin
    logic [15:0] ra;
    logic        rn;
    bit          stale;

    tbl[0] = '{16'h0001, 1'b1, 16'hFFFF, 1'b0};
    tbl[1] = '{16'h1234, 1'b0, 16'h1234, 1'b0};
    tbl[2] = '{16'h0000, 1'b1, 16'h0000, 1'b0};
    tbl[3] = '{16'h8000, 1'b1, 16'h8000, 1'b1};
    tbl[4] = '{16'h8000, 1'b0, 16'h8000, 1'b0};
    tbl[5] = '{16'hFFFF, 1'b1, 16'h0001, 1'b0};
    tbl[6] = '{16'h7FFF, 1'b1, 16'h8001, 1'b0};
    tbl[7] = '{16'h00F0, 1'b1, 16'hFF10, 1'b0};
    tbl[8] = '{16'h1234, 1'b1, 16'hEDCC, 1'b0};

    #1;
    chk("rst_in_ready", ir16, 1);
    chk("rst_out_valid", ov16, 0);
    chk("rst_busy", busy16, 0);
    chk("rst_z", z16, 0);
`ifdef AU_NEG_C_SERIAL_OVF_EN
    chk("rst_ovf", ovf16, 0);
`endif
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) op16(tbl[i].a, tbl[i].neg, 0, 1'b0, tbl[i].z, tbl[i].ovf);

    // Backpressure: consumer stalls three cycles in DONE.
    op16(16'h1234, 1'b1, 3, 1'b0, 16'hEDCC, 1'b0);

    // Reset pulsed two cycles into RUN discards the operation.
    a16 = 16'h00FF; neg16 = 1'b1; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrun_busy", busy16, 1);
    rst_n = 1'b0; #1;
    chk("abort_out_valid", ov16, 0);
    chk("abort_z", z16, 0);
    chk("abort_in_ready", ir16, 1);
    chk("abort_busy", busy16, 0);
    #2 rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ov16 || busy16) stale = 1'b1;
    end
    chk("no_stale_result", stale, 0);

    op16(16'h0001, 1'b1, 0, 1'b0, 16'hFFFF, 1'b0);

    // Randomized ops with stray in_valid while busy and random stalls.
    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom);
      if (n % 8 == 0) ra = 16'h8000;
      rn = 1'($urandom_range(0, 1));
      op16(ra, rn, $urandom_range(0, 2), 1'b1, model16(ra, rn), rn && (ra == 16'h8000));
    end

    // Partial last slice.
    op10(10'h001, 1'b1, 10'h3FF, 1'b0);
    op10(10'h200, 1'b1, 10'h200, 1'b1);
    op10(10'h155, 1'b0, 10'h155, 1'b0);
    op10(10'h0F0, 1'b1, 10'h310, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
